// File: rtl/bus_mux_pkg.sv
// Shared constants and width helpers for the bus_mux_rr N-master bus multiplexer.
package bus_mux_pkg;

  localparam int ARB_FIXED = 32'sd0;
  localparam int ARB_RR    = 32'sd1;

  function automatic int idx_w(input int n);
    if (n <= 32'sd1) return 32'sd1;
    else return $clog2(n);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 32'sd1;
  endfunction

endpackage

// File: rtl/resp_order_fifo.sv
// Ordering FIFO of master indices for accepted reads; head is the master owed the next response.
module resp_order_fifo
  import bus_mux_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = idx_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s, do_pop_s;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) return {PTR_W{1'b0}};
    else return ptr + {{(PTR_W-1){1'b0}}, 1'b1};
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == {CNT_W{1'b0}});
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy; push+pop together keeps the count.
  always_comb begin
    do_push_s = push_i & ~full_o;
    do_pop_s  = pop_i & ~empty_o;
    wr_ptr_d  = do_push_s ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = do_pop_s ? next_ptr(rd_ptr_q) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // Pointer, count and storage registers.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push_s) mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/bus_mux_rr.sv
// N-master to 1-slave req/ack/resp bus mux with fixed or round-robin arbitration and pipelined read ordering.
// Optional sticky error output err_o is enabled by defining BUS_MUX_RR_ERR_EN.
module bus_mux_rr
  import bus_mux_pkg::*;
#(
  parameter int N_MASTERS   = 2,
  parameter int OUTSTANDING = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ARB_MODE    = 1,
  localparam int BE_W  = DATA_W / 8,
  localparam int IDX_W = idx_w(N_MASTERS),
  localparam int CNT_W = cnt_w(OUTSTANDING)
) (
  input  logic                        clk_i,
  input  logic                        arst_n_i,
`ifdef BUS_MUX_RR_ERR_EN
  output logic                        err_o,
`endif
  input  logic [N_MASTERS-1:0]        m_req_i,
  input  logic [N_MASTERS-1:0]        m_we_i,
  input  logic [N_MASTERS*ADDR_W-1:0] m_addr_bi,
  input  logic [N_MASTERS*BE_W-1:0]   m_be_bi,
  input  logic [N_MASTERS*DATA_W-1:0] m_wdata_bi,
  output logic [N_MASTERS-1:0]        m_ack_o,
  output logic [N_MASTERS-1:0]        m_resp_o,
  output logic [N_MASTERS*DATA_W-1:0] m_rdata_bo,
  output logic                        s_req_o,
  output logic                        s_we_o,
  output logic [ADDR_W-1:0]           s_addr_bo,
  output logic [BE_W-1:0]             s_be_bo,
  output logic [DATA_W-1:0]           s_wdata_bo,
  input  logic                        s_ack_i,
  input  logic                        s_resp_i,
  input  logic [DATA_W-1:0]           s_rdata_bi
);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d, lock_idx_q, lock_idx_d, gnt_idx_s, fifo_head_s;
  logic             lock_vld_q, lock_vld_d, gnt_vld_s, stall_s, accept_s, push_s, lock_drop_s;
  logic             fifo_full_s, fifo_empty_s;
  logic [CNT_W-1:0] fifo_cnt_s;
  int               cand_s;

  // Grant select: a held lock wins, otherwise scan from rr_ptr (RR) or from index 0 (fixed).
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_idx_s = {IDX_W{1'b0}};
    cand_s    = 32'sd0;
    if (lock_vld_q) begin
      gnt_vld_s = m_req_i[lock_idx_q];
      gnt_idx_s = lock_idx_q;
    end else begin
      for (int i = 0; i < N_MASTERS; i++) begin
        cand_s = ((ARB_MODE == ARB_RR) ? int'(rr_ptr_q) : 32'sd0) + i;
        if (cand_s >= N_MASTERS) cand_s = cand_s - N_MASTERS;
        else cand_s = cand_s;
        if (!gnt_vld_s && m_req_i[cand_s]) begin
          gnt_vld_s = 1'b1;
          gnt_idx_s = IDX_W'(cand_s);
        end else begin
          gnt_vld_s = gnt_vld_s;
        end
      end
    end
  end

  // Reads stall on the registered count so a same-cycle pop cannot open a slot.
  assign stall_s     = gnt_vld_s & ~m_we_i[gnt_idx_s] & (fifo_cnt_s == CNT_W'(OUTSTANDING));
  assign accept_s    = gnt_vld_s & ~stall_s & s_ack_i;
  assign push_s      = accept_s & ~m_we_i[gnt_idx_s] & ~fifo_full_s;
  assign lock_drop_s = lock_vld_q & ~m_req_i[lock_idx_q];

  // Slave-side mux and master ack; everything forced low while reset is asserted.
  always_comb begin
    s_req_o    = 1'b0;
    s_we_o     = 1'b0;
    s_addr_bo  = {ADDR_W{1'b0}};
    s_be_bo    = {BE_W{1'b0}};
    s_wdata_bo = {DATA_W{1'b0}};
    m_ack_o    = {N_MASTERS{1'b0}};
    if (arst_n_i && gnt_vld_s) begin
      s_req_o    = ~stall_s;
      s_we_o     = m_we_i[gnt_idx_s];
      s_addr_bo  = m_addr_bi[int'(gnt_idx_s)*ADDR_W +: ADDR_W];
      s_be_bo    = m_be_bi[int'(gnt_idx_s)*BE_W +: BE_W];
      s_wdata_bo = m_wdata_bi[int'(gnt_idx_s)*DATA_W +: DATA_W];
      m_ack_o[gnt_idx_s] = accept_s;
    end else begin
      m_ack_o = {N_MASTERS{1'b0}};
    end
  end

  // Response routing to the FIFO head; responses with an empty FIFO are dropped.
  always_comb begin
    m_resp_o   = {N_MASTERS{1'b0}};
    m_rdata_bo = {(N_MASTERS*DATA_W){1'b0}};
    if (arst_n_i && s_resp_i && !fifo_empty_s) begin
      m_resp_o[fifo_head_s] = 1'b1;
      m_rdata_bo[int'(fifo_head_s)*DATA_W +: DATA_W] = s_rdata_bi;
    end else begin
      m_resp_o = {N_MASTERS{1'b0}};
    end
  end

  // Lock and round-robin pointer next-state.
  always_comb begin
    lock_vld_d = lock_vld_q;
    lock_idx_d = lock_idx_q;
    if (lock_vld_q) begin
      if (lock_drop_s || accept_s) lock_vld_d = 1'b0;
      else lock_vld_d = 1'b1;
    end else if (gnt_vld_s && !stall_s && !s_ack_i) begin
      lock_vld_d = 1'b1;
      lock_idx_d = gnt_idx_s;
    end else begin
      lock_vld_d = 1'b0;
    end
    if (!accept_s) rr_ptr_d = rr_ptr_q;
    else if (gnt_idx_s == IDX_W'(N_MASTERS - 1)) rr_ptr_d = {IDX_W{1'b0}};
    else rr_ptr_d = gnt_idx_s + {{(IDX_W-1){1'b0}}, 1'b1};
  end

  // Arbitration state registers.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rr_ptr_q   <= {IDX_W{1'b0}};
      lock_vld_q <= 1'b0;
      lock_idx_q <= {IDX_W{1'b0}};
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_vld_q <= lock_vld_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  resp_order_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (OUTSTANDING)
  ) u_fifo (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .push_i   (push_s),
    .din_i    (gnt_idx_s),
    .pop_i    (s_resp_i),
    .head_o   (fifo_head_s),
    .full_o   (fifo_full_s),
    .empty_o  (fifo_empty_s),
    .count_o  (fifo_cnt_s)
  );

`ifdef BUS_MUX_RR_ERR_EN
  logic err_q, err_d;

  // Sticky error on a spurious response or an abandoned lock.
  always_comb begin
    err_d = err_q | (s_resp_i & fifo_empty_s) | lock_drop_s;
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) err_q <= 1'b0;
    else err_q <= err_d;
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_bus_mux_rr.sv
// Directed scoreboard bench for bus_mux_rr: a 4-master RR instance and a 2-master fixed-priority instance.
module tb_bus_mux_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic arst_n;

  logic [3:0]   a_req, a_we, a_ack, a_resp;
  logic [127:0] a_addr, a_wdata, a_rdata;
  logic [15:0]  a_be;
  logic         a_sreq, a_swe, a_sack, a_sresp;
  logic [31:0]  a_saddr, a_swdata, a_srdata;
  logic [3:0]   a_sbe;

  logic [1:0]   b_req, b_we, b_ack, b_resp;
  logic [63:0]  b_addr, b_wdata, b_rdata;
  logic [7:0]   b_be;
  logic         b_sreq, b_swe, b_sack, b_sresp;
  logic [31:0]  b_saddr, b_swdata, b_srdata;
  logic [3:0]   b_sbe;

`ifdef BUS_MUX_RR_ERR_EN
  logic a_err, b_err;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int q_a[$];
  int q_b[$];

  bus_mux_rr #(.N_MASTERS(4), .OUTSTANDING(2), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1)) dut_a (
    .clk_i(clk), .arst_n_i(arst_n),
`ifdef BUS_MUX_RR_ERR_EN
    .err_o(a_err),
`endif
    .m_req_i(a_req), .m_we_i(a_we), .m_addr_bi(a_addr), .m_be_bi(a_be), .m_wdata_bi(a_wdata),
    .m_ack_o(a_ack), .m_resp_o(a_resp), .m_rdata_bo(a_rdata),
    .s_req_o(a_sreq), .s_we_o(a_swe), .s_addr_bo(a_saddr), .s_be_bo(a_sbe), .s_wdata_bo(a_swdata),
    .s_ack_i(a_sack), .s_resp_i(a_sresp), .s_rdata_bi(a_srdata)
  );

  bus_mux_rr #(.N_MASTERS(2), .OUTSTANDING(4), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0)) dut_b (
    .clk_i(clk), .arst_n_i(arst_n),
`ifdef BUS_MUX_RR_ERR_EN
    .err_o(b_err),
`endif
    .m_req_i(b_req), .m_we_i(b_we), .m_addr_bi(b_addr), .m_be_bi(b_be), .m_wdata_bi(b_wdata),
    .m_ack_o(b_ack), .m_resp_o(b_resp), .m_rdata_bo(b_rdata),
    .s_req_o(b_sreq), .s_we_o(b_swe), .s_addr_bo(b_saddr), .s_be_bo(b_sbe), .s_wdata_bo(b_swdata),
    .s_ack_i(b_sack), .s_resp_i(b_sresp), .s_rdata_bi(b_srdata)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int k, input logic req, input logic we, input logic [31:0] addr);
    a_req[k] = req;
    a_we[k]  = we;
    a_addr[k*32 +: 32]  = addr;
    a_wdata[k*32 +: 32] = addr ^ 32'hA5A5_0000;
    a_be[k*4 +: 4]      = 4'hF;
  endtask

  task automatic set_b(input int k, input logic req, input logic we, input logic [31:0] addr);
    b_req[k] = req;
    b_we[k]  = we;
    b_addr[k*32 +: 32]  = addr;
    b_wdata[k*32 +: 32] = addr ^ 32'h5A5A_0000;
    b_be[k*4 +: 4]      = 4'hF;
  endtask

  task automatic resp_a(input string tag, input logic [31:0] data);
    int idx;
    if (q_a.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s: observed response with empty scoreboard expected a queued read", tag);
    end else begin
      idx = q_a.pop_front();
      chk({tag, "_resp"}, {124'd0, a_resp}, 128'd1 << idx);
      chk({tag, "_data"}, a_rdata, {96'd0, data} << (32 * idx));
    end
  endtask

  task automatic resp_b(input string tag, input logic [31:0] data);
    int idx;
    if (q_b.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s: observed response with empty scoreboard expected a queued read", tag);
    end else begin
      idx = q_b.pop_front();
      chk({tag, "_resp"}, {126'd0, b_resp}, 128'd1 << idx);
      chk({tag, "_data"}, {64'd0, b_rdata}, {96'd0, data} << (32 * idx));
    end
  endtask

  initial begin
    arst_n = 1'b0;
    a_req = 4'hF; a_we = 4'h0; a_addr = 128'd0; a_wdata = 128'd0; a_be = 16'd0;
    a_sack = 1'b1; a_sresp = 1'b1; a_srdata = 32'hDEAD_BEEF;
    b_req = 2'b11; b_we = 2'b00; b_addr = 64'd0; b_wdata = 64'd0; b_be = 8'd0;
    b_sack = 1'b1; b_sresp = 1'b1; b_srdata = 32'hDEAD_BEEF;

    // Reset held with live inputs: every output must be quiet.
    @(negedge clk);
    chk("rst_a_sreq", {127'd0, a_sreq}, 128'd0);
    chk("rst_a_ack", {124'd0, a_ack}, 128'd0);
    chk("rst_a_resp", {124'd0, a_resp}, 128'd0);
    chk("rst_a_rdata", a_rdata, 128'd0);
    chk("rst_a_saddr", {96'd0, a_saddr}, 128'd0);
    chk("rst_b_sreq", {127'd0, b_sreq}, 128'd0);
`ifdef BUS_MUX_RR_ERR_EN
    chk("rst_a_err", {127'd0, a_err}, 128'd0);
`endif
    a_req = 4'h0; a_sresp = 1'b0; b_req = 2'b00; b_sresp = 1'b0;
    tick();
    arst_n = 1'b1;
    tick();

    // Fixed priority, two simultaneous reads.
    set_b(0, 1'b1, 1'b0, 32'h100);
    set_b(1, 1'b1, 1'b0, 32'h200);
    @(negedge clk);
    chk("fx_ack0", {126'd0, b_ack}, 128'h1);
    chk("fx_addr0", {96'd0, b_saddr}, 128'h100);
    q_b.push_back(0);
    tick();
    b_req[0] = 1'b0;
    @(negedge clk);
    chk("fx_ack1", {126'd0, b_ack}, 128'h2);
    chk("fx_addr1", {96'd0, b_saddr}, 128'h200);
    q_b.push_back(1);
    tick();
    b_req = 2'b00; b_sresp = 1'b1; b_srdata = 32'hD0;
    @(negedge clk);
    resp_b("fx_r0", 32'hD0);
    tick();
    b_srdata = 32'hD1;
    @(negedge clk);
    resp_b("fx_r1", 32'hD1);
    tick();
    b_sresp = 1'b0;
    // Master 0 keeps winning in fixed mode.
    set_b(0, 1'b1, 1'b1, 32'h300);
    set_b(1, 1'b1, 1'b1, 32'h400);
    @(negedge clk);
    chk("fx_prio_a", {126'd0, b_ack}, 128'h1);
    tick();
    set_b(0, 1'b1, 1'b1, 32'h304);
    @(negedge clk);
    chk("fx_prio_b", {126'd0, b_ack}, 128'h1);
    chk("fx_prio_we", {127'd0, b_swe}, 128'h1);
    tick();
    b_req = 2'b00;

    // Round robin, four continuous writers.
    for (int k = 0; k < 4; k++) set_a(k, 1'b1, 1'b1, 32'h1000 + k);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("rr_ack_%0d", c), {124'd0, a_ack}, 128'd1 << (c % 4));
      chk($sformatf("rr_addr_%0d", c), {96'd0, a_saddr}, 128'h1000 + (c % 4));
      chk($sformatf("rr_wdata_%0d", c), {96'd0, a_swdata}, {96'd0, (32'h1000 + (c % 4)) ^ 32'hA5A5_0000});
      tick();
    end
    a_req = 4'h0;

    // Lock: slave stalls master 0 while master 1 (next in RR order) requests.
    a_sack = 1'b0;
    set_a(0, 1'b1, 1'b1, 32'h2000);
    @(negedge clk);
    chk("lk_sreq", {127'd0, a_sreq}, 128'h1);
    chk("lk_ack0", {124'd0, a_ack}, 128'h0);
    tick();
    set_a(1, 1'b1, 1'b1, 32'h2100);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("lk_hold_%0d", c), {96'd0, a_saddr}, 128'h2000);
      chk($sformatf("lk_noack_%0d", c), {124'd0, a_ack}, 128'h0);
      tick();
    end
    a_sack = 1'b1;
    @(negedge clk);
    chk("lk_ack", {124'd0, a_ack}, 128'h1);
    chk("lk_addr", {96'd0, a_saddr}, 128'h2000);
    tick();
    a_req[0] = 1'b0;
    @(negedge clk);
    chk("lk_next", {124'd0, a_ack}, 128'h2);
    chk("lk_next_addr", {96'd0, a_saddr}, 128'h2100);
    tick();
    a_req = 4'h0;

    // Outstanding limit of 2: reads from master 2, write from master 1 while full.
    set_a(2, 1'b1, 1'b0, 32'h3000);
    @(negedge clk);
    chk("st_rd1", {124'd0, a_ack}, 128'h4);
    q_a.push_back(2);
    tick();
    set_a(2, 1'b1, 1'b0, 32'h3004);
    @(negedge clk);
    chk("st_rd2", {124'd0, a_ack}, 128'h4);
    q_a.push_back(2);
    tick();
    set_a(2, 1'b1, 1'b0, 32'h3008);
    set_a(1, 1'b1, 1'b1, 32'h3100);
    @(negedge clk);
    chk("st_wr_ack", {124'd0, a_ack}, 128'h2);
    chk("st_wr_sreq", {127'd0, a_sreq}, 128'h1);
    chk("st_wr_noresp", {124'd0, a_resp}, 128'h0);
    tick();
    a_req[1] = 1'b0;
    @(negedge clk);
    chk("st_stall_sreq", {127'd0, a_sreq}, 128'h0);
    chk("st_stall_ack", {124'd0, a_ack}, 128'h0);
    tick();
    a_sresp = 1'b1; a_srdata = 32'hA1;
    @(negedge clk);
    resp_a("st_r1", 32'hA1);
    chk("st_stall_pop", {127'd0, a_sreq}, 128'h0);
    tick();
    a_sresp = 1'b0;
    @(negedge clk);
    chk("st_rd3", {124'd0, a_ack}, 128'h4);
    q_a.push_back(2);
    tick();
    a_req[2] = 1'b0; a_sresp = 1'b1; a_srdata = 32'hA2;
    @(negedge clk);
    resp_a("st_r2", 32'hA2);
    tick();
    // New read accepted in the same cycle as a response.
    set_a(3, 1'b1, 1'b0, 32'h4000);
    a_srdata = 32'hA3;
    @(negedge clk);
    resp_a("st_r3", 32'hA3);
    chk("st_rd4", {124'd0, a_ack}, 128'h8);
    q_a.push_back(3);
    tick();
    a_req[3] = 1'b0; a_srdata = 32'hB4;
    @(negedge clk);
    resp_a("st_r4", 32'hB4);
    tick();
    a_srdata = 32'hEE;
    @(negedge clk);
    chk("sp_resp", {124'd0, a_resp}, 128'h0);
    chk("sp_rdata", a_rdata, 128'h0);
    tick();
    a_sresp = 1'b0;
    @(negedge clk);
`ifdef BUS_MUX_RR_ERR_EN
    chk("sp_err", {127'd0, a_err}, 128'h1);
`endif
    chk("sp_idle", {124'd0, a_resp}, 128'h0);

    // Reset with a read outstanding: the late response is spurious.
    set_a(0, 1'b1, 1'b0, 32'h5000);
    @(negedge clk);
    chk("mr_ack", {124'd0, a_ack}, 128'h1);
    tick();
    a_req = 4'h0; arst_n = 1'b0;
    @(negedge clk);
    chk("mr_sreq", {127'd0, a_sreq}, 128'h0);
`ifdef BUS_MUX_RR_ERR_EN
    chk("mr_err_clr", {127'd0, a_err}, 128'h0);
`endif
    tick();
    arst_n = 1'b1; a_sresp = 1'b1; a_srdata = 32'h55;
    @(negedge clk);
    chk("mr_resp", {124'd0, a_resp}, 128'h0);
    tick();
    a_sresp = 1'b0;

    // Locked master abandons its request before ack.
    a_sack = 1'b0;
    set_a(0, 1'b1, 1'b1, 32'h6000);
    @(negedge clk);
    chk("ld_sreq", {127'd0, a_sreq}, 128'h1);
    tick();
    a_req[0] = 1'b0;
    set_a(1, 1'b1, 1'b1, 32'h6100);
    @(negedge clk);
    chk("ld_locked", {127'd0, a_sreq}, 128'h0);
    tick();
    a_sack = 1'b1;
    @(negedge clk);
    chk("ld_release", {124'd0, a_ack}, 128'h2);
    chk("ld_addr", {96'd0, a_saddr}, 128'h6100);
`ifdef BUS_MUX_RR_ERR_EN
    chk("ld_err", {127'd0, a_err}, 128'h1);
`endif
    tick();
    a_req = 4'h0;

    chk("sb_a_empty", 128'(q_a.size()), 128'd0);
    chk("sb_b_empty", 128'(q_b.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_mux_rr.md
# bus_mux_rr

N-master to 1-slave bus multiplexer for the req/ack/resp memory bus, the parametrised successor of the two-master debug/CPU data-port mux in the SoC top. It arbitrates N masters onto one slave port with fixed-priority or round-robin selection. It tracks up to OUTSTANDING pipelined reads in an ordering FIFO, so read responses are routed back to the issuing master without the single-read-in-flight limit.

## Interface
- N_MASTERS, 2: number of master ports, 2..16; index 0 is the debug/UDM master by convention.
- OUTSTANDING, 4: maximum accepted-but-unanswered reads, power of two, 1..16.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; byte-enable width BE_W = DATA_W/8.
- ARB_MODE, 1: 0 = fixed priority (lowest index wins), 1 = round-robin.
- clk_i  in  1  single clock, all state on rising edge.
- arst_n_i  in  1  asynchronous active-low reset.
- m_req_i  in  N_MASTERS  per-master request.
- m_we_i  in  N_MASTERS  per-master write enable.
- m_addr_bi  in  N_MASTERS*ADDR_W  packed addresses, master k at [k*ADDR_W +: ADDR_W].
- m_be_bi  in  N_MASTERS*BE_W  packed byte enables.
- m_wdata_bi  in  N_MASTERS*DATA_W  packed write data.
- m_ack_o  out  N_MASTERS  per-master request accept.
- m_resp_o  out  N_MASTERS  per-master read response strobe.
- m_rdata_bo  out  N_MASTERS*DATA_W  packed read data; zero for non-responding masters.
- s_req_o, s_we_o  out  1  slave request and write enable.
- s_addr_bo  out  ADDR_W  slave address.
- s_be_bo  out  BE_W  slave byte enables.
- s_wdata_bo  out  DATA_W  slave write data.
- s_ack_i, s_resp_i  in  1  slave accept and read response.
- s_rdata_bi  in  DATA_W  slave read data.

## Operation
- Bus protocol:
  - A master holds req and its fields stable until ack.
  - A transfer is accepted in the cycle where req & ack are both high.
  - Writes get no response.
  - A read gets exactly one resp cycle later, in order.
- Grant select:
  - Fixed mode: lowest-index requesting master.
  - RR mode: first requester at or after rr_ptr, wrapping modulo N_MASTERS.
- rr_ptr update:
  - On every accepted transfer, rr_ptr <= granted index + 1, wrapping N_MASTERS-1 -> 0.
  - In fixed mode rr_ptr is unused.
- Lock:
  - When s_req_o=1 and s_ack_i=0, the lock register captures the granted index.
  - While locked, grant stays on that master regardless of other requests; the lock clears on ack.
  - If the locked master drops req before ack (a protocol violation), the lock clears the next cycle.
- Slave mux:
  - s_* carry the granted master's fields.
  - With no grant, all s_* are zero.
  - m_ack_o[g] = s_ack_i for the granted master only; zero for all others.
- Read stall:
  - When the FIFO count == OUTSTANDING and the granted request is a read, s_req_o=0 and m_ack_o=0.
  - This holds even if a pop occurs in the same cycle (the check uses the registered count).
  - Writes are never stalled by the FIFO.
- Ordering FIFO:
  - Push the granted index on an accepted read.
  - Pop on s_resp_i when the FIFO is non-empty.
  - Push and pop in the same cycle leave the count unchanged.
- Response route:
  - m_resp_o[head] = s_resp_i.
  - m_rdata_bo slice[head] = s_rdata_bi.
  - All other slices are zero.
- Spurious response (s_resp_i while the FIFO is empty) is dropped: no m_resp_o.

## Timing
- Request and ack paths are combinational: zero added latency.
- Response path is combinational from s_resp_i and the registered FIFO head: zero added latency.
- A read may be accepted in the same cycle as the response to an earlier read.
- Back-to-back accepts from different masters are allowed on consecutive cycles.
- Reset (arst_n_i=0, asynchronous):
  - rr_ptr=0, lock cleared, FIFO empty.
  - All outputs are 0 while reset is held.
- Reset mid-operation:
  - Outstanding read tags are discarded.
  - Slave responses arriving after reset release are treated as spurious.

## Configuration
- BUS_MUX_RR_ERR_EN defined:
  - Adds output err_o (1 bit), reset 0.
  - err_o sets sticky on a spurious response or on a lock dropped without ack.
  - err_o clears only on reset.
- BUS_MUX_RR_ERR_EN undefined: no err_o port; both events are silently ignored.

## Structure
- Package bus_mux_pkg holds:
  - ARB_FIXED=0 and ARB_RR=1 constants.
  - Index-width helper: IDX_W = max(1, clog2(N_MASTERS)).
  - Count-width helper: clog2(OUTSTANDING)+1.
- Sub-module resp_order_fifo, parameters WIDTH=IDX_W and DEPTH=OUTSTANDING:
  - Registered storage, head output, full/empty/count.
  - Simultaneous push and pop supported.

## Test plan
- N=2, fixed mode, both masters request a read at once, slave acks immediately -> master 0 acked first, master 1 acked the next cycle; responses routed to 0 then 1.
- N=4, RR mode, all four request continuously, slave always acks -> grant order 0,1,2,3,0; each master acked once per 4 cycles.
- Slave holds ack low 3 cycles while master 0 is granted and master 1 raises req -> s_addr_bo stays master 0's address until ack; master 1 granted after.
- OUTSTANDING=2, three reads from master 2 with resp delayed -> third read stalled (s_req_o=0) until the first resp, then accepted; data 0xA1,0xA2,0xA3 arrive on master 2 in order.
- Write from master 1 while FIFO full -> accepted the same cycle; no m_resp_o generated.
- s_resp_i pulse with FIFO empty -> no m_resp_o; with BUS_MUX_RR_ERR_EN, err_o=1 the next cycle and stays 1 until arst_n_i=0.
